alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, 1, number of clock cycles operands are held on the ALU before its result is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  sequencer can accept a command.
REQ-006 Port: cmd_op  input  4  ALU function select; bit0..bit3 map to F0..F3.
REQ-007 Port: cmd_a  input  8  operand A, used when cmd_use_acc=0.
REQ-008 Port: cmd_b  input  8  operand B.
REQ-009 Port: cmd_use_acc  input  1  1 = take operand A from the accumulator instead of cmd_a.
REQ-010 Port: alu_a, alu_b  output  8 each  registered operands to the ALU A/B inputs.
REQ-011 Port: alu_f0, alu_f1, alu_f2, alu_f3  output  1 each  registered function select to ALU F0..F3.
REQ-012 Port: alu_q  input  8  ALU result Q.
REQ-013 Port: alu_carry  input  1  ALU Carry.
REQ-014 Port: res_valid  output  1  result available.
REQ-015 Port: res_ready  input  1  consumer accepts result.
REQ-016 Port: res_q  output  8  captured result.
REQ-017 Port: res_carry  output  1  captured carry.
REQ-018 Port: res_zero  output  1  1 when captured result equals 0x00.
REQ-019 Port: acc  output  8  accumulator, last captured result.

Function
REQ-020 FSM states SHALL be IDLE, SETTLE, RESULT; no other reachable states.
REQ-021 cmd_ready SHALL be 1 in IDLE only (registered state decode, no combinational path from cmd_valid).
REQ-022 Accept = cmd_valid & cmd_ready at an edge; at that edge alu_a <= (cmd_use_acc ? acc : cmd_a), alu_b <= cmd_b, alu_f3..f0 <= cmd_op, settle counter <= SETTLE_CYCLES-1, state -> SETTLE.
REQ-023 cmd_use_acc SHALL use the acc value registered before the accepting edge.
REQ-024 In SETTLE: counter nonzero -> decrement; counter zero -> at that edge capture res_q <= alu_q, res_carry <= alu_carry, res_zero <= (alu_q==0), acc <= alu_q, res_valid <= 1, state -> RESULT.
REQ-025 Latency: accept at edge N -> res_valid high after edge N+SETTLE_CYCLES; alu_q sampled at edge N+SETTLE_CYCLES.
REQ-026 In RESULT: res_valid=1, res_q/res_carry/res_zero/acc stable; res_ready=1 at an edge -> res_valid <= 0, state -> IDLE; res_ready=0 -> hold indefinitely.
REQ-027 res_ready high on the first RESULT cycle SHALL complete the transfer at the next edge (one-cycle RESULT).
REQ-028 Next command acceptable no earlier than the first IDLE cycle; max throughput one command per SETTLE_CYCLES+2 cycles.
REQ-029 alu_a/alu_b/alu_f* SHALL hold their last values outside SETTLE until the next accept.
REQ-030 cmd_valid in SETTLE/RESULT SHALL be ignored and not latched; cmd_* may change freely there.
REQ-031 Arithmetic: none in this block; all widths 8 bits, no truncation or extension.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, counter 0, and all outputs 0 (cmd_ready becomes 1 after release), acc 0, regardless of state.
REQ-033 Reset mid-SETTLE or mid-RESULT SHALL discard the pending result; no res_valid pulse follows.
REQ-034 rst has priority over accept and capture in the same cycle.

Verification
REQ-035 Reset then idle: rst 2 cycles -> all outputs 0, cmd_ready=1, acc=0x00.
REQ-036 Single op, SETTLE_CYCLES=1: accept cmd_a=0x35, cmd_b=0x12, cmd_op=0x9; stub alu_q=0x47, carry 0 -> alu_a=0x35, alu_b=0x12, alu_f0=1, alu_f3=1 after edge N; res_valid after edge N+1, res_q=0x47, res_zero=0, acc=0x47.
REQ-037 Accumulate: acc=0x47, accept cmd_use_acc=1, cmd_a=0xFF, cmd_b=0x01; stub alu_q=0x00, carry 1 -> alu_a=0x47, res_q=0x00, res_carry=1, res_zero=1, acc=0x00.
REQ-038 Backpressure: res_ready=0 for 5 cycles, cmd_valid=1 with new command -> res_valid stays 1, outputs stable, cmd_ready=0, command not accepted; res_ready=1 -> IDLE, then accept.
REQ-039 SETTLE_CYCLES=4: alu_q changes 0x11 -> 0x22 at edge N+3 -> res_q=0x22, res_valid after edge N+4 exactly.
REQ-040 Reset mid-SETTLE (edge N+1, SETTLE_CYCLES=4) -> no res_valid, acc=0x00, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Sequences one command at a time onto an external combinational ALU:
//   registers operands and function select, waits SETTLE_CYCLES edges for
//   the ALU to settle, captures Q/Carry into a result register (also kept
//   as the accumulator) and holds it until the consumer takes it.
//
// Parameters
//   SETTLE_CYCLES  cycles operands are held before Q is sampled (1..15)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_a, cmd_b            function select and operands
//   cmd_use_acc                     take operand A from acc instead of cmd_a
//   alu_a, alu_b, alu_f0..alu_f3    registered drive to the ALU
//   alu_q, alu_carry                ALU result inputs
//   res_valid/res_ready             result handshake
//   res_q, res_carry, res_zero      captured result
//   acc                             accumulator (last captured result)
module alu_operand_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_use_acc,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_f0,
    output logic       alu_f1,
    output logic       alu_f2,
    output logic       alu_f3,
    input  logic [7:0] alu_q,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_q,
    output logic       res_carry,
    output logic       res_zero,
    output logic [7:0] acc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       release_res;

    // Pure decode of the state register; gated by rst so every output
    // reads 0 while reset is held and no command can slip in alongside it.
    assign cmd_ready = (state == IDLE) && !rst;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            {alu_f3, alu_f2, alu_f1, alu_f0} <= 4'h0;
            res_valid <= 1'b0;
            res_q     <= 8'h00;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            acc       <= 8'h00;
        end else begin
            if (accept) begin
                // acc here is the value registered before this edge.
                alu_a <= cmd_use_acc ? acc : cmd_a;
                alu_b <= cmd_b;
                {alu_f3, alu_f2, alu_f1, alu_f0} <= cmd_op;
                cnt   <= CNT_INIT;
            end else if (state == SETTLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                res_q     <= alu_q;
                res_carry <= alu_carry;
                res_zero  <= (alu_q == 8'h00);
                acc       <= alu_q;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    typedef struct packed {
        logic [7:0] q;
        logic       c;
        logic       z;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    res_t sb1[$];
    res_t sb4[$];

    // DUT with SETTLE_CYCLES=1
    logic       rst1, cv1, cr1, ua1, rv1, rr1, f01, f11, f21, f31, ac1, rc1, rz1;
    logic [3:0] op1;
    logic [7:0] a1, b1, aa1, ab1, q1, rq1, acc1;
    // DUT with SETTLE_CYCLES=4
    logic       rst4, cv4, cr4, ua4, rv4, rr4, f04, f14, f24, f34, ac4, rc4, rz4;
    logic [3:0] op4;
    logic [7:0] a4, b4, aa4, ab4, q4, rq4, acc4;

    alu_operand_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst1), .cmd_valid(cv1), .cmd_ready(cr1), .cmd_op(op1),
        .cmd_a(a1), .cmd_b(b1), .cmd_use_acc(ua1), .alu_a(aa1), .alu_b(ab1),
        .alu_f0(f01), .alu_f1(f11), .alu_f2(f21), .alu_f3(f31),
        .alu_q(q1), .alu_carry(ac1), .res_valid(rv1), .res_ready(rr1),
        .res_q(rq1), .res_carry(rc1), .res_zero(rz1), .acc(acc1));

    alu_operand_sequencer #(.SETTLE_CYCLES(4)) u4 (
        .clk(clk), .rst(rst4), .cmd_valid(cv4), .cmd_ready(cr4), .cmd_op(op4),
        .cmd_a(a4), .cmd_b(b4), .cmd_use_acc(ua4), .alu_a(aa4), .alu_b(ab4),
        .alu_f0(f04), .alu_f1(f14), .alu_f2(f24), .alu_f3(f34),
        .alu_q(q4), .alu_carry(ac4), .res_valid(rv4), .res_ready(rr4),
        .res_q(rq4), .res_carry(rc4), .res_zero(rz4), .acc(acc4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop1(input string tag);
        res_t e;
        if (sb1.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb1.pop_front();
            chk({tag, "_valid"}, 32'(rv1), 32'd1);
            chk({tag, "_q"},     32'(rq1), 32'(e.q));
            chk({tag, "_carry"}, 32'(rc1), 32'(e.c));
            chk({tag, "_zero"},  32'(rz1), 32'(e.z));
            chk({tag, "_acc"},   32'(acc1), 32'(e.q));
        end
    endtask

    task automatic pop4(input string tag);
        res_t e;
        if (sb4.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb4.pop_front();
            chk({tag, "_valid"}, 32'(rv4), 32'd1);
            chk({tag, "_q"},     32'(rq4), 32'(e.q));
            chk({tag, "_carry"}, 32'(rc4), 32'(e.c));
            chk({tag, "_zero"},  32'(rz4), 32'(e.z));
            chk({tag, "_acc"},   32'(acc4), 32'(e.q));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst1 = 1; cv1 = 0; op1 = 0; a1 = 0; b1 = 0; ua1 = 0; q1 = 0; ac1 = 0; rr1 = 0;
        rst4 = 1; cv4 = 0; op4 = 0; a4 = 0; b4 = 0; ua4 = 0; q4 = 0; ac4 = 0; rr4 = 0;

        // Reset for two cycles: everything zero, then ready after release.
        step(); step();
        chk("rst_ready",  32'(cr1), 32'd0);
        chk("rst_valid",  32'(rv1), 32'd0);
        chk("rst_alu_a",  32'(aa1), 32'd0);
        chk("rst_fsel",   32'({f31, f21, f11, f01}), 32'd0);
        chk("rst_res",    32'({rq1, rc1, rz1}), 32'd0);
        chk("rst_acc",    32'(acc1), 32'd0);
        rst1 = 0; rst4 = 0;
        #1;
        chk("rel_ready",  32'(cr1), 32'd1);
        chk("rel_ready4", 32'(cr4), 32'd1);

        // Single op, SETTLE_CYCLES=1.
        cv1 = 1; a1 = 8'h35; b1 = 8'h12; op1 = 4'h9; ua1 = 0; q1 = 8'h47; ac1 = 0;
        sb1.push_back('{q: 8'h47, c: 1'b0, z: 1'b0});
        step();                                   // edge N: accept
        cv1 = 0;
        chk("op_alu_a",   32'(aa1), 32'h35);
        chk("op_alu_b",   32'(ab1), 32'h12);
        chk("op_fsel",    32'({f31, f21, f11, f01}), 32'h9);
        chk("op_ready0",  32'(cr1), 32'd0);
        chk("op_nvalid",  32'(rv1), 32'd0);
        step();                                   // edge N+1: capture
        pop1("op");
        rr1 = 1;
        step();
        rr1 = 0;
        chk("op_done_valid", 32'(rv1), 32'd0);
        chk("op_done_ready", 32'(cr1), 32'd1);

        // Accumulate: operand A comes from acc (0x47), cmd_a ignored.
        cv1 = 1; ua1 = 1; a1 = 8'hFF; b1 = 8'h01; op1 = 4'h6; q1 = 8'h00; ac1 = 1;
        sb1.push_back('{q: 8'h00, c: 1'b1, z: 1'b1});
        step();
        cv1 = 0; ua1 = 0;
        chk("acc_alu_a",  32'(aa1), 32'h47);
        chk("acc_alu_b",  32'(ab1), 32'h01);
        step();
        pop1("accum");

        // Backpressure: result held, new command refused.
        cv1 = 1; a1 = 8'hAA; b1 = 8'h55; op1 = 4'h3; q1 = 8'hFF; ac1 = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(rv1), 32'd1);
            chk("bp_hold",  32'({rq1, rc1, rz1, acc1}), 32'({8'h00, 1'b1, 1'b1, 8'h00}));
            chk("bp_ready", 32'(cr1), 32'd0);
            chk("bp_alu_a", 32'(aa1), 32'h47);
        end
        rr1 = 1;
        step();                                   // RESULT -> IDLE
        chk("bp_rel_valid", 32'(rv1), 32'd0);
        chk("bp_rel_ready", 32'(cr1), 32'd1);
        sb1.push_back('{q: 8'hFF, c: 1'b0, z: 1'b0});
        step();                                   // waiting command accepted
        cv1 = 0;
        chk("bp_acc_alu_a", 32'(aa1), 32'hAA);
        chk("bp_acc_alu_b", 32'(ab1), 32'h55);
        step();                                   // capture; res_ready already high
        pop1("bp_res");
        step();                                   // one-cycle RESULT
        chk("one_cyc_valid", 32'(rv1), 32'd0);
        chk("one_cyc_ready", 32'(cr1), 32'd1);
        rr1 = 0;

        // SETTLE_CYCLES=4: Q changes after edge N+3, sampled at edge N+4.
        cv4 = 1; a4 = 8'h01; b4 = 8'h02; op4 = 4'h5; q4 = 8'h11; ac4 = 0;
        sb4.push_back('{q: 8'h22, c: 1'b0, z: 1'b0});
        step();                                   // edge N
        cv4 = 0;
        chk("s4_alu_a", 32'(aa4), 32'h01);
        for (int i = 1; i <= 3; i++) begin
            step();                               // edges N+1..N+3
            chk("s4_nvalid", 32'(rv4), 32'd0);
            chk("s4_ready0", 32'(cr4), 32'd0);
        end
        q4 = 8'h22;
        step();                                   // edge N+4
        pop4("s4");
        rr4 = 1;
        step();
        rr4 = 0;
        chk("s4_done", 32'(rv4), 32'd0);

        // Reset in the middle of SETTLE discards the pending result.
        cv4 = 1; a4 = 8'h10; b4 = 8'h20; op4 = 4'hA; q4 = 8'h99;
        step();                                   // edge N: accept
        cv4 = 0;
        rst4 = 1;
        step();                                   // edge N+1: reset
        rst4 = 0;
        #1;
        chk("mid_rst_ready", 32'(cr4), 32'd1);
        chk("mid_rst_acc",   32'(acc4), 32'd0);
        chk("mid_rst_alu_a", 32'(aa4), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_nvalid", 32'(rv4), 32'd0);
            chk("mid_rst_acc_hold", 32'(acc4), 32'd0);
        end
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        chk("sb4_drained", 32'(sb4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
